// File: rtl/cla_share_scheduler.sv
// ============================================================================
// cla_share_scheduler : round-robin sharing of one external CLA adder among
// NREQ requesters. Optional port rsp_ovf is built when OVF_DETECT_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cla_share_scheduler #(
   parameter int WIDTH      = 8,
   parameter int NREQ       = 4,
   parameter int SETTLE_CYC = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [NREQ*WIDTH-1:0]     req_a,
   input  logic [NREQ*WIDTH-1:0]     req_b,
   input  logic [NREQ-1:0]           req_cin,
   output logic [NREQ-1:0]           req_ready,
   output logic [WIDTH-1:0]          adder_a,
   output logic [WIDTH-1:0]          adder_b,
   output logic                      adder_cin,
   input  logic [WIDTH-1:0]          adder_sum,
   input  logic                      adder_cout,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [$clog2(NREQ)-1:0]   rsp_id,
   output logic [WIDTH-1:0]          rsp_sum,
   output logic                      rsp_cout
`ifdef OVF_DETECT_EN
   ,
   output logic                      rsp_ovf
`endif
);

   localparam int         c_IDW      = $clog2(NREQ);
   localparam logic [3:0] c_CNT_INIT = 4'(SETTLE_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t             r_state;
   logic [c_IDW-1:0]   r_ptr;
   logic [c_IDW-1:0]   r_id;
   logic [3:0]         r_cnt;

   logic [NREQ-1:0]    w_grant;
   logic [c_IDW-1:0]   w_gid;
   logic               w_found;
   logic [WIDTH-1:0]   w_sel_a;
   logic [WIDTH-1:0]   w_sel_b;
   logic               w_sel_cin;

   // Search starts at the pointer and wraps; first valid requester wins.
   always_comb begin
      logic [c_IDW:0]   v_sum;
      logic [c_IDW-1:0] v_idx;
      w_grant = '0;
      w_gid   = '0;
      w_found = 1'b0;
      v_sum   = '0;
      v_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         v_sum = {1'b0, r_ptr} + (c_IDW+1)'(k);
         if (v_sum >= (c_IDW+1)'(NREQ))
            v_sum = v_sum - (c_IDW+1)'(NREQ);
         v_idx = v_sum[c_IDW-1:0];
         if (!w_found && req_valid[v_idx]) begin
            w_found        = 1'b1;
            w_grant[v_idx] = 1'b1;
            w_gid          = v_idx;
         end
      end
   end

   always_comb begin
      w_sel_a   = '0;
      w_sel_b   = '0;
      w_sel_cin = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         w_sel_a   = w_sel_a   | (req_a[k*WIDTH +: WIDTH] & {WIDTH{w_grant[k]}});
         w_sel_b   = w_sel_b   | (req_b[k*WIDTH +: WIDTH] & {WIDTH{w_grant[k]}});
         w_sel_cin = w_sel_cin | (req_cin[k] & w_grant[k]);
      end
   end

   // Gated by reset so no grant is visible while reset is held.
   assign req_ready = (r_state == S_IDLE && !reset) ? w_grant : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_ptr     <= '0;
         r_id      <= '0;
         r_cnt     <= '0;
         adder_a   <= '0;
         adder_b   <= '0;
         adder_cin <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_sum   <= '0;
         rsp_cout  <= 1'b0;
`ifdef OVF_DETECT_EN
         rsp_ovf   <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  adder_a   <= w_sel_a;
                  adder_b   <= w_sel_b;
                  adder_cin <= w_sel_cin;
                  r_id      <= w_gid;
                  r_cnt     <= c_CNT_INIT;
                  r_ptr     <= (w_gid == c_IDW'(NREQ - 1)) ? '0 : w_gid + 1'b1;
                  r_state   <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (r_cnt == 4'd0) begin
                  rsp_sum   <= adder_sum;
                  rsp_cout  <= adder_cout;
                  rsp_id    <= r_id;
                  rsp_valid <= 1'b1;
`ifdef OVF_DETECT_EN
                  rsp_ovf   <= (adder_a[WIDTH-1] == adder_b[WIDTH-1]) &&
                               (adder_sum[WIDTH-1] != adder_a[WIDTH-1]);
`endif
                  r_state   <= S_RESP;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_cla_share_scheduler.sv
// ============================================================================
// tb_cla_share_scheduler : directed + random checks of cla_share_scheduler
// against a transaction-level reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cla_share_scheduler;

   localparam int W   = 8;
   localparam int N   = 4;
   localparam int SC  = 1;
   localparam int IDW = $clog2(N);

   logic             clk = 1'b0;
   logic             reset;
   logic [N-1:0]     req_valid, req_cin, req_ready;
   logic [N*W-1:0]   req_a, req_b;
   logic [W-1:0]     adder_a, adder_b, adder_sum, rsp_sum;
   logic             adder_cin, adder_cout, rsp_valid, rsp_ready, rsp_cout;
   logic [IDW-1:0]   rsp_id;

   logic [N-1:0]     v_req_valid, v_req_cin, v_req_ready;
   logic [N*W-1:0]   v_req_a, v_req_b;
   logic [W-1:0]     v_adder_a, v_adder_b, v_adder_sum, v_rsp_sum;
   logic             v_adder_cin, v_adder_cout, v_rsp_valid, v_rsp_ready, v_rsp_cout;
   logic [IDW-1:0]   v_rsp_id;
`ifdef OVF_DETECT_EN
   logic             rsp_ovf, v_rsp_ovf;
`endif

   always #5 clk = ~clk;

   // The external adder.
   assign {adder_cout, adder_sum}     = adder_a + adder_b + adder_cin;
   assign {v_adder_cout, v_adder_sum} = v_adder_a + v_adder_b + v_adder_cin;

   cla_share_scheduler #(.WIDTH(W), .NREQ(N), .SETTLE_CYC(SC)) u_dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_cin(req_cin), .req_ready(req_ready), .adder_a(adder_a), .adder_b(adder_b),
      .adder_cin(adder_cin), .adder_sum(adder_sum), .adder_cout(adder_cout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
`ifdef OVF_DETECT_EN
      , .rsp_ovf(rsp_ovf)
`endif
   );

   cla_share_scheduler #(.WIDTH(W), .NREQ(N), .SETTLE_CYC(4)) u_dut4 (
      .clk(clk), .reset(reset), .req_valid(v_req_valid), .req_a(v_req_a), .req_b(v_req_b),
      .req_cin(v_req_cin), .req_ready(v_req_ready), .adder_a(v_adder_a), .adder_b(v_adder_b),
      .adder_cin(v_adder_cin), .adder_sum(v_adder_sum), .adder_cout(v_adder_cout),
      .rsp_valid(v_rsp_valid), .rsp_ready(v_rsp_ready), .rsp_id(v_rsp_id),
      .rsp_sum(v_rsp_sum), .rsp_cout(v_rsp_cout)
`ifdef OVF_DETECT_EN
      , .rsp_ovf(v_rsp_ovf)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: a pending-result countdown plus a rotating priority pointer.
   int       m_ptr, m_wait, m_id;
   bit       m_rsp;
   logic [W-1:0] m_a, m_b, m_sum;
   logic     m_cin, m_cout;
   int       gq[$];
   logic [IDW-1:0] last_id;
   logic [W-1:0]   last_sum;
   logic           last_cout;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr  = 0;
      m_wait = 0;
      m_rsp  = 1'b0;
   endtask

   task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
      req_cin[i]      = c;
   endtask

   // One clock cycle: inputs already driven; check at negedge, advance model, return at posedge+1.
   task automatic cycle();
      int g;
      int idx;
      logic [N-1:0] exp_rdy;
      logic [W:0]   full;
      @(negedge clk);
      g = -1;
      if (!m_rsp && m_wait == 0) begin
         for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (g < 0 && req_valid[idx]) g = idx;
         end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_rsp));
      if (m_rsp) begin
         chk("rsp_id", 64'(rsp_id), 64'(m_id));
         chk("rsp_sum", 64'(rsp_sum), 64'(m_sum));
         chk("rsp_cout", 64'(rsp_cout), 64'(m_cout));
      end
      if (m_wait > 0) begin
         chk("adder_ops", 64'({adder_a, adder_b, adder_cin}), 64'({m_a, m_b, m_cin}));
      end
      if (req_ready != '0) gq.push_back($clog2(req_ready));
      if (rsp_valid && rsp_ready) begin
         last_id   = rsp_id;
         last_sum  = rsp_sum;
         last_cout = rsp_cout;
      end
      if (m_rsp) begin
         if (rsp_ready) m_rsp = 1'b0;
      end else if (m_wait > 0) begin
         m_wait--;
         if (m_wait == 0) m_rsp = 1'b1;
      end else if (g >= 0) begin
         m_id   = g;
         m_a    = req_a[g*W +: W];
         m_b    = req_b[g*W +: W];
         m_cin  = req_cin[g];
         full   = {1'b0, m_a} + {1'b0, m_b} + {{W{1'b0}}, m_cin};
         m_sum  = full[W-1:0];
         m_cout = full[W];
         m_wait = SC;
         m_ptr  = (g + 1) % N;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; rsp_ready = 1'b1;
      v_req_valid = '0; v_req_a = '0; v_req_b = '0; v_req_cin = '0; v_rsp_ready = 1'b1;
      model_reset();
      @(posedge clk); #1;
      req_valid = 4'b1111;
      #1;
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_adder", 64'({adder_a, adder_b, adder_cin}), 64'(0));
      chk("rst_rsp", 64'({rsp_id, rsp_sum, rsp_cout}), 64'(0));
      req_valid = '0;
      @(posedge clk); #1;
      reset = 1'b0;

      // Single op from requester 0.
      req_valid = 4'b0001; set_op(0, 8'h0F, 8'h01, 1'b0);
      cycle();
      req_valid = '0;
      cycle(); cycle();
      chk("t1_result", 64'({last_id, last_sum, last_cout}), 64'({2'd0, 8'h10, 1'b0}));

      // Carry-out and wrap from requester 2.
      req_valid = 4'b0100; set_op(2, 8'hFF, 8'h01, 1'b1);
      cycle();
      req_valid = '0;
      cycle(); cycle();
      chk("t2_result", 64'({last_id, last_sum, last_cout}), 64'({2'd2, 8'h01, 1'b1}));
`ifdef OVF_DETECT_EN
      req_valid = 4'b0100; set_op(2, 8'h7F, 8'h01, 1'b0);
      cycle();
      req_valid = '0;
      cycle();
      @(negedge clk);
      chk("t2_ovf", 64'(rsp_ovf), 64'(1));
      @(posedge clk); #1;
      m_rsp = 1'b0;
`endif

      // Round-robin with all requesters valid from reset.
      reset = 1'b1; #1; model_reset();
      @(posedge clk); #1; reset = 1'b0;
      for (int i = 0; i < N; i++) set_op(i, 8'(i * 16 + 3), 8'(8'h20 + i), i[0]);
      req_valid = 4'b1111;
      gq.delete();
      repeat (15) cycle();
      chk("rr_count", 64'(gq.size()), 64'(5));
      for (int i = 0; i < 5 && i < gq.size(); i++) chk("rr_order", 64'(gq[i]), 64'(i % N));

      // Backpressure with requester 1 waiting.
      req_valid = 4'b0010; set_op(1, 8'h5A, 8'hA5, 1'b1); rsp_ready = 1'b0;
      repeat (12) cycle();
      rsp_ready = 1'b1;
      gq.delete();
      cycle(); cycle();
      chk("bp_regrant", 64'(gq.size() == 1 ? gq[0] : -1), 64'(1));
      req_valid = '0;
      repeat (3) cycle();

      // Randomized traffic.
      repeat (400) begin
         req_valid = 4'($urandom);
         req_a     = 32'($urandom);
         req_b     = 32'($urandom);
         req_cin   = 4'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      rsp_ready = 1'b1;
      req_valid = '0;
      repeat (6) cycle();

      // Reset while requester 2's op is executing.
      req_valid = 4'b0100; set_op(2, 8'h31, 8'h42, 1'b0);
      cycle();
      req_valid = '0;
      reset = 1'b1;
      #1;
      chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("mid_rst_outs", 64'({req_ready, adder_a, adder_b, adder_cin}), 64'(0));
      chk("mid_rst_rsp", 64'({rsp_id, rsp_sum, rsp_cout}), 64'(0));
      model_reset();
      @(posedge clk); #1; reset = 1'b0;
      req_valid = 4'b1100; set_op(3, 8'h11, 8'h22, 1'b1);
      gq.delete();
      cycle();
      chk("mid_rst_ptr", 64'(gq.size() == 1 ? gq[0] : -1), 64'(2));
      req_valid = '0;
      cycle(); cycle();
      chk("mid_rst_replay", 64'({last_id, last_sum, last_cout}), 64'({2'd2, 8'h73, 1'b0}));

      // Four-cycle settle instance.
      v_req_valid = 4'b0001;
      v_req_a[7:0] = 8'h33; v_req_b[7:0] = 8'h44; v_req_cin[0] = 1'b1;
      @(negedge clk);
      chk("s4_ready", 64'(v_req_ready), 64'(4'b0001));
      @(posedge clk); #1;
      v_req_valid = '0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("s4_hold", 64'({v_adder_a, v_adder_b, v_adder_cin}), 64'({8'h33, 8'h44, 1'b1}));
         chk("s4_not_yet", 64'(v_rsp_valid), 64'(0));
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("s4_valid", 64'(v_rsp_valid), 64'(1));
      chk("s4_result", 64'({v_rsp_id, v_rsp_sum, v_rsp_cout}), 64'({2'd0, 8'h78, 1'b0}));
      @(posedge clk); #1;
      @(negedge clk);
      chk("s4_done", 64'(v_rsp_valid), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
